slow_to_fast_event_sync: RTL

- Carries single-cycle events, each with a DATA_W-bit payload, from the slow clock domain (clkb) into the fast clock domain (clka).
- Uses a toggle request/acknowledge handshake, so no event is ever duplicated and no accepted event is ever lost.
- Events that arrive while a transfer is still in flight are dropped and counted.
- It is the return-path companion of the fast-to-slow pulse synchronizer, and sits between slow-domain control logic and fast-domain consumers.

---
 rtl/slow_to_fast_event_sync.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/slow_to_fast_event_sync.sv
// slow_to_fast_event_sync
//
// Carries single-cycle events with a DATA_W-bit payload from the slow clkb
// domain into the fast clka domain using a toggle request/acknowledge
// handshake. Exactly one valid_a is produced per accepted event. Events that
// arrive while a transfer is in flight are dropped and counted in a saturating
// counter. The design stays correct when clka is slower than clkb; only the
// throughput changes.
//
// Parameters
//   DATA_W      payload width in bits (1..32)
//   SYNC_STAGES synchronizer flops per crossing (2..4)
//   CNT_W       width of the saturating drop counter
//
// Ports
//   clka        fast destination clock, rising edge
//   rst         asynchronous active-low reset, clears both domains
//   clkb        slow source clock, rising edge, asynchronous to clka
//   evt_b       clkb: one-cycle event strobe
//   data_b      clkb: payload, sampled when evt_b is high
//   busy_b      clkb: a transfer is in flight
//   drop_cnt_b  clkb: events rejected while busy, saturating
//   valid_a     clka: one-cycle strobe marking a delivered event
//   data_a      clka: delivered payload, held until the next valid_a
module slow_to_fast_event_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              clkb,
  input  logic              evt_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              busy_b,
  output logic [CNT_W-1:0]  drop_cnt_b,
  output logic              valid_a,
  output logic [DATA_W-1:0] data_a
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Source (clkb) domain state
  state_t                 state_reg;
  logic                   req_tgl_b_reg;
  logic [DATA_W-1:0]      hold_b_reg;
  logic [CNT_W-1:0]       drop_cnt_reg;
  logic                   busy_reg;
  logic [SYNC_STAGES-1:0] ack_sync_reg;

  // Destination (clka) domain state
  logic [SYNC_STAGES-1:0] req_sync_reg;
  logic                   req_last_reg;
  logic                   ack_tgl_a_reg;
  logic                   valid_reg;
  logic [DATA_W-1:0]      data_a_reg;

  logic ack_sync_b;
  logic req_sync_a;
  logic req_edge_a;

  assign ack_sync_b = ack_sync_reg[SYNC_STAGES-1];
  assign req_sync_a = req_sync_reg[SYNC_STAGES-1];
  assign req_edge_a = req_sync_a ^ req_last_reg;

  // --------------------------------------------------------------------------
  // Source side. The accept/drop decision uses the registered state, so an
  // event on the same edge that returns to IDLE is still dropped.
  // hold_b_reg is frozen for the whole WAIT period; clka samples it only
  // after the synchronized request arrives, so it needs no synchronizer.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      req_tgl_b_reg <= 1'b0;
      hold_b_reg    <= '0;
      drop_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      ack_sync_reg  <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_tgl_a_reg};
      case (state_reg)
        S_IDLE: begin
          if (evt_b) begin
            hold_b_reg    <= data_b;
            req_tgl_b_reg <= ~req_tgl_b_reg;
            busy_reg      <= 1'b1;
            state_reg     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (evt_b && (drop_cnt_reg != CNT_MAX)) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
          end
          // Handshake completes once the acknowledge toggle has caught up.
          if (ack_sync_b == req_tgl_b_reg) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Destination side. Any change of the synchronized request toggle is one
  // new event; the acknowledge simply mirrors the request value it consumed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      req_sync_reg  <= '0;
      req_last_reg  <= 1'b0;
      ack_tgl_a_reg <= 1'b0;
      valid_reg     <= 1'b0;
      data_a_reg    <= '0;
    end else begin
      req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], req_tgl_b_reg};
      req_last_reg <= req_sync_a;
      valid_reg    <= req_edge_a;
      if (req_edge_a) begin
        data_a_reg    <= hold_b_reg;
        ack_tgl_a_reg <= req_sync_a;
      end
    end
  end

  assign busy_b     = busy_reg;
  assign drop_cnt_b = drop_cnt_reg;
  assign valid_a    = valid_reg;
  assign data_a     = data_a_reg;

endmodule
